wb_rtc_alarm: RTL and testbench
===============================

// Module: wb_rtc_alarm
// PURPOSE
//  Next-generation Wishbone RTC for the Caravel user area: programmable prescaler, 32-bit seconds counter,
//  N_ALARMS independent compare channels (one-shot or repeating) with maskable IRQs. Sits behind the
//  user_project_wrapper Wishbone slave port; irq drives user_irq[N_ALARMS-1:0].
// PARAMETERS
//  BASE_ADDR   32'h3000_0000  slave base; decode adr[31:8]==BASE_ADDR[31:8]
//  PRESCALE_W  24             prescaler divider width
//  DIV_RESET   24'd10_000_000 DIV reset value (10 MHz wb_clk_i -> 1 Hz tick)
//  N_ALARMS    3              alarm channels, legal 1..8
// PORTS
//  wb_clk_i   in   1           sole clock
//  wb_rst_i   in   1           reset, asynchronous, active-high
//  wbs_cyc_i  in   1           Wishbone cycle
//  wbs_stb_i  in   1           Wishbone strobe
//  wbs_we_i   in   1           1=write
//  wbs_sel_i  in   4           byte enables (writes)
//  wbs_adr_i  in   32          byte address
//  wbs_dat_i  in   32          write data
//  wbs_dat_o  out  32          read data, valid with ack
//  wbs_ack_o  out  1           one-cycle acknowledge
//  irq        out  N_ALARMS    per-channel interrupt, registered
//  tick_o     out  1           one-cycle pulse per second increment
// BEHAVIOUR
//  Reset: all outputs 0; CTRL=0, DIV=DIV_RESET, SEC=0, PEND=0, ALARMi=0xFFFF_FFFF, ACFGi=0, prescaler=0.
//  Registers (offset adr[7:0], word aligned):
//   0x00 CTRL  [0]EN.  0x04 DIV [PRESCALE_W-1:0].  0x08 SEC.  0x0C PEND [N-1:0], write-1-to-clear.
//   0x10+8i ALARMi 32b compare.  0x14+8i ACFGi [0]AEN [1]IEN [2]REPEAT.  Unmapped: read 0, write ignored.
//  Wishbone: access = cyc&stb&decode&!ack. ack asserted the cycle after access, exactly 1 cycle, then low
//   >=1 cycle (no back-to-back acks). Write commits on access cycle, byte lanes per wbs_sel_i. dat_o
//   registered with ack, 0 otherwise. Non-decoded stb: no ack (bus timeout upstream).
//  Prescaler: when EN, counts 0..eff_div-1; eff_div = (DIV==0)?1:DIV. At eff_div-1: wraps to 0, tick=1.
//   EN=0 freezes prescaler and SEC (no reset of count). Write to DIV or SEC zeroes prescaler.
//  SEC: +1 on tick, wraps 0xFFFF_FFFF->0. SEC write in same cycle as tick: write wins, no increment.
//  tick_o registered: high the cycle SEC shows the new value.
//  Alarm i fires when a tick moves SEC to value == ALARMi and AEN=1 (SEC writes never fire).
//   Fire: PEND[i]<=1; if REPEAT=0 then AEN<=0; if REPEAT=1, AEN stays, fires again after full 2^32 wrap
//   or new ALARMi write. Multiple channels may fire the same cycle.
//  PEND W1C in same cycle as fire of that bit: set wins (stays 1).
//  irq[i] <= PEND[i] & IEN; updates one cycle after PEND; IEN=0 masks but PEND still latches.
//  Reset mid-transaction: ack, dat_o drop to 0 immediately (async); master must retry.
// TESTING
//  1 Reset -> ack=0,irq=0,tick_o=0; read DIV=DIV_RESET, ALARM0=0xFFFF_FFFF, SEC=0.
//  2 DIV=4, CTRL=1 -> tick_o every 4 clocks; after 12 clocks SEC=3; DIV=0 -> tick every clock.
//  3 SEC=9, ALARM1=10, ACFG1=3 -> next tick: PEND=0b010, irq[1]=1 one cycle later, AEN1 cleared;
//    write PEND=0b010 -> irq[1]=0.
//  4 Two channels same ALARM=5, one REPEAT -> both fire; W1C on the tick cycle -> PEND bit remains 1.
//  5 SEC=0xFFFF_FFFF, DIV=1 -> next tick SEC=0; SEC write colliding with tick -> written value held.
//  6 Reads/writes: sel=4'b0001 on ALARM0 changes byte 0 only; unmapped offset 0xFC reads 0; acks one
//    cycle each, never back-to-back; wb_rst_i pulse mid-access kills ack.

Source files
------------

// File: rtl/wb_rtc_alarm.sv
// Wishbone RTC: programmable prescaler, 32-bit seconds counter, N_ALARMS compare channels with
// one-shot/repeat modes and registered per-channel interrupts.

module wb_rtc_alarm_ch (
  input  logic        clk,
  input  logic        rst,
  input  logic        alarm_wr,
  input  logic        cfg_wr,
  input  logic [3:0]  sel,
  input  logic [31:0] wdata,
  input  logic        step,
  input  logic [31:0] sec_next,
  input  logic        pend_clr,
  output logic [31:0] alarm,
  output logic [2:0]  cfg,
  output logic        pend,
  output logic        irq
);
  logic fire;
  // cfg = {REPEAT, IEN, AEN}
  assign fire = step & cfg[0] & (sec_next == alarm);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm <= '1;
      cfg   <= '0;
      pend  <= 1'b0;
      irq   <= 1'b0;
    end else begin
      if (alarm_wr)
        for (int b = 0; b < 4; b++)
          if (sel[b]) alarm[8*b +: 8] <= wdata[8*b +: 8];
      // An explicit config write overrides the one-shot auto-disarm.
      if (cfg_wr && sel[0]) cfg <= wdata[2:0];
      else if (fire && !cfg[2]) cfg[0] <= 1'b0;
      pend <= fire | (pend & ~pend_clr);
      irq  <= pend & cfg[1];
    end
  end
endmodule

module wb_rtc_alarm #(
  parameter logic [31:0]           BASE_ADDR  = 32'h3000_0000,
  parameter int                    PRESCALE_W = 24,
  parameter logic [PRESCALE_W-1:0] DIV_RESET  = 24'd10_000_000,
  parameter int                    N_ALARMS   = 3
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_adr_i,
  input  logic [31:0]         wbs_dat_i,
  output logic [31:0]         wbs_dat_o,
  output logic                wbs_ack_o,
  output logic [N_ALARMS-1:0] irq,
  output logic                tick_o
);
  function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  logic [7:0]            off;
  logic                  access, wr, ctrl_wr, div_wr, sec_wr, pend_wr;
  logic                  en, cnt_last, tick, step;
  logic [PRESCALE_W-1:0] div, cnt, eff_div;
  logic [31:0]           sec, sec_next, div32, div_new, rdata;

  logic [N_ALARMS-1:0]       alarm_wr, cfg_wr, pend, pend_clr;
  logic [N_ALARMS-1:0][31:0] alarm;
  logic [N_ALARMS-1:0][2:0]  cfg;

  assign off     = wbs_adr_i[7:0];
  // The !ack term guarantees at least one idle cycle between acks.
  assign access  = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~wbs_ack_o;
  assign wr      = access & wbs_we_i;
  assign ctrl_wr = wr & (off == 8'h00);
  assign div_wr  = wr & (off == 8'h04);
  assign sec_wr  = wr & (off == 8'h08);
  assign pend_wr = wr & (off == 8'h0C);

  always_comb begin
    div32 = '0;
    div32[PRESCALE_W-1:0] = div;
  end
  assign div_new  = merge(div32, wbs_dat_i, wbs_sel_i);

  assign eff_div  = (div == '0) ? PRESCALE_W'(1) : div;
  assign cnt_last = (cnt == eff_div - PRESCALE_W'(1));
  assign tick     = en & cnt_last;
  // A colliding SEC write swallows the tick: no increment, no alarm, no tick_o.
  assign step     = tick & ~sec_wr;
  assign sec_next = sec + 32'd1;

  for (genvar i = 0; i < N_ALARMS; i++) begin : g_ch
    assign alarm_wr[i] = wr & (off == 8'(16 + 8*i));
    assign cfg_wr[i]   = wr & (off == 8'(20 + 8*i));
    assign pend_clr[i] = pend_wr & wbs_sel_i[0] & wbs_dat_i[i];
    wb_rtc_alarm_ch u_ch (
      .clk(wb_clk_i), .rst(wb_rst_i), .alarm_wr(alarm_wr[i]), .cfg_wr(cfg_wr[i]),
      .sel(wbs_sel_i), .wdata(wbs_dat_i), .step(step), .sec_next(sec_next),
      .pend_clr(pend_clr[i]), .alarm(alarm[i]), .cfg(cfg[i]), .pend(pend[i]), .irq(irq[i])
    );
  end

  always_comb begin
    rdata = '0;
    case (off)
      8'h00:   rdata[0] = en;
      8'h04:   rdata = div32;
      8'h08:   rdata = sec;
      8'h0C:   rdata[N_ALARMS-1:0] = pend;
      default: for (int i = 0; i < N_ALARMS; i++) begin
        if (off == 8'(16 + 8*i)) rdata = alarm[i];
        if (off == 8'(20 + 8*i)) rdata[2:0] = cfg[i];
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      tick_o    <= 1'b0;
      en        <= 1'b0;
      div       <= DIV_RESET;
      sec       <= '0;
      cnt       <= '0;
    end else begin
      wbs_ack_o <= access;
      wbs_dat_o <= (access & ~wbs_we_i) ? rdata : '0;
      tick_o    <= step;
      if (ctrl_wr && wbs_sel_i[0]) en <= wbs_dat_i[0];
      if (div_wr) div <= div_new[PRESCALE_W-1:0];
      if (div_wr || sec_wr) cnt <= '0;
      else if (en)          cnt <= cnt_last ? '0 : cnt + PRESCALE_W'(1);
      if (sec_wr)    sec <= merge(sec, wbs_dat_i, wbs_sel_i);
      else if (tick) sec <= sec_next;
    end
  end
endmodule

// File: tb/tb_wb_rtc_alarm.sv
// Scoreboard bench for wb_rtc_alarm: a cycle-level register model predicts every bus response,
// irq and tick_o; a monitor compares DUT outputs against it.

module tb_wb_rtc_alarm;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int          N    = 3;
  localparam logic [23:0] DIVR = 24'd10_000_000;

  logic          clk = 1'b0, rst = 1'b1;
  logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]    sel = '0;
  logic [31:0]   adr = '0, wdat = '0;
  logic [31:0]   dat_o;
  logic          ack, tick_o;
  logic [N-1:0]  irq;
  int            checks = 0, errors = 0;

  always #5 clk = ~clk;

  wb_rtc_alarm dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_dat_o(dat_o), .wbs_ack_o(ack),
    .irq(irq), .tick_o(tick_o)
  );

  typedef struct { bit rd; logic [31:0] d; } exp_t;
  exp_t q[$];

  // reference model state
  bit           m_en, m_ack, m_tick_o;
  int unsigned  m_div, m_cnt;
  logic [31:0]  m_sec;
  logic [31:0]  m_alarm [N];
  bit           m_aen [N], m_ien [N], m_rep [N];
  logic [N-1:0] m_pend, m_irq;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rd_model(input logic [7:0] o);
    if (o == 8'h00) return {31'd0, m_en};
    if (o == 8'h04) return m_div;
    if (o == 8'h08) return m_sec;
    if (o == 8'h0C) return {{(32-N){1'b0}}, m_pend};
    for (int i = 0; i < N; i++) begin
      if (o == 8'(16 + 8*i)) return m_alarm[i];
      if (o == 8'(20 + 8*i)) return {29'd0, m_rep[i], m_ien[i], m_aen[i]};
    end
    return 32'd0;
  endfunction

  task automatic m_reset();
    m_en = 0; m_div = DIVR; m_sec = 0; m_cnt = 0; m_pend = '0; m_irq = '0;
    m_ack = 0; m_tick_o = 0;
    for (int i = 0; i < N; i++) begin
      m_alarm[i] = 32'hFFFF_FFFF; m_aen[i] = 0; m_ien[i] = 0; m_rep[i] = 0;
    end
    q.delete();
  endtask

  task automatic m_step();
    logic [7:0]   o;
    logic [31:0]  ns, t;
    logic [N-1:0] fire, clr;
    bit acc, w, tk, secw, stp;
    int unsigned eff;
    o    = adr[7:0];
    acc  = cyc && stb && (adr[31:8] == BASE[31:8]) && !m_ack;
    w    = acc && we;
    if (acc) q.push_back('{rd: !we, d: rd_model(o)});
    eff  = (m_div == 0) ? 1 : m_div;
    tk   = m_en && (m_cnt == eff - 1);
    secw = w && (o == 8'h08);
    stp  = tk && !secw;
    ns   = m_sec + 32'd1;
    for (int i = 0; i < N; i++) begin
      fire[i]  = stp && m_aen[i] && (m_alarm[i] == ns);
      m_irq[i] = m_pend[i] && m_ien[i];
    end
    m_tick_o = stp;
    m_ack    = acc;
    if (w && (o == 8'h04 || o == 8'h08)) m_cnt = 0;
    else if (m_en) m_cnt = tk ? 0 : m_cnt + 1;
    if (secw) m_sec = mrg(m_sec, wdat, sel);
    else if (stp) m_sec = ns;
    clr    = (w && o == 8'h0C && sel[0]) ? wdat[N-1:0] : '0;
    m_pend = (m_pend & ~clr) | fire;
    for (int i = 0; i < N; i++) begin
      if (w && o == 8'(16 + 8*i)) m_alarm[i] = mrg(m_alarm[i], wdat, sel);
      if (w && o == 8'(20 + 8*i) && sel[0]) begin
        m_aen[i] = wdat[0]; m_ien[i] = wdat[1]; m_rep[i] = wdat[2];
      end else if (fire[i] && !m_rep[i]) m_aen[i] = 0;
    end
    if (w && o == 8'h00 && sel[0]) m_en = wdat[0];
    if (w && o == 8'h04) begin
      t = mrg(m_div, wdat, sel);
      m_div = t[23:0];
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else m_step();
    end
  end

  // monitor: per-cycle output comparison and scoreboard pop on every ack
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      chk("ack", ack, m_ack);
      chk("irq", irq, m_irq);
      chk("tick_o", tick_o, m_tick_o);
      if (ack || m_ack) begin
        if (q.size() == 0) chk("ack_without_request", ack, 0);
        else begin
          e = q.pop_front();
          if (ack && e.rd) chk("rdata", dat_o, e.d);
        end
      end
      if (!ack) chk("dat_idle", dat_o, 0);
    end
  end

  task automatic wb(input logic [7:0] o, input bit w, input logic [31:0] d,
                    input logic [3:0] s, input bit now);
    bit got;
    got = 0;
    if (!now) @(negedge clk);
    cyc = 1; stb = 1; we = w; adr = BASE | {24'd0, o}; wdat = d; sel = s;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (ack) begin got = 1; break; end
    end
    chk("bus_ack_seen", got, 1);
    @(negedge clk);
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic wr(input logic [7:0] o, input logic [31:0] d);
    wb(o, 1, d, 4'hF, 0);
  endtask

  task automatic rd(input logic [7:0] o);
    wb(o, 0, 32'd0, 4'hF, 0);
  endtask

  // issue a write whose access edge coincides with a prescaler tick
  task automatic wr_on_tick(input logic [7:0] o, input logic [31:0] d);
    bit hit;
    hit = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (m_en && m_cnt == ((m_div == 0) ? 0 : m_div - 1)) begin hit = 1; break; end
    end
    chk("tick_align", hit, 1);
    wb(o, 1, d, 4'hF, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  o;
    logic [31:0] d;
    logic [3:0]  s;
    repeat (3) @(negedge clk);
    rst = 0;
    chk("reset_ack", ack, 0);
    chk("reset_irq", irq, 0);
    chk("reset_tick", tick_o, 0);
    rd(8'h04); rd(8'h10); rd(8'h08); rd(8'h00); rd(8'h0C); rd(8'h14);

    // prescaler
    wr(8'h04, 4); wr(8'h00, 1);
    idle(12); rd(8'h08);
    wr(8'h04, 0); idle(5); rd(8'h08);

    // one-shot alarm with irq, then W1C
    wr(8'h00, 0); wr(8'h08, 9); wr(8'h18, 10); wr(8'h1C, 3); wr(8'h04, 3); wr(8'h00, 1);
    idle(8); rd(8'h0C); rd(8'h1C); rd(8'h08);
    wr(8'h0C, 32'h2); idle(3); rd(8'h0C);

    // two channels on same value, one repeating; W1C lands on the firing tick
    wr(8'h00, 0); wr(8'h10, 5); wr(8'h20, 5); wr(8'h14, 3); wr(8'h24, 7);
    wr(8'h04, 6); wr(8'h08, 4); wr(8'h00, 1);
    wr_on_tick(8'h0C, 32'h5);
    rd(8'h0C); rd(8'h14); rd(8'h24);

    // seconds wrap and SEC write colliding with a tick
    wr(8'h00, 0); wr(8'h08, 32'hFFFF_FFFF); wr(8'h04, 1); wr(8'h00, 1);
    rd(8'h08);
    wr(8'h04, 5);
    wr_on_tick(8'h08, 32'h0000_1234);
    rd(8'h08);

    // byte lanes, unmapped, non-decoded
    wb(8'h10, 1, 32'hA5A5_A5A5, 4'b0001, 0); rd(8'h10);
    wb(8'h10, 1, 32'h1234_5678, 4'b0110, 0); rd(8'h10);
    rd(8'hFC); wr(8'hFC, 32'hDEAD_BEEF); rd(8'hFC);
    @(negedge clk); cyc = 1; stb = 1; we = 0; adr = 32'h3000_0100;
    idle(3); cyc = 0; stb = 0;
    idle(2);

    // reset pulse while ack is high
    @(negedge clk); cyc = 1; stb = 1; we = 0; adr = BASE | 32'h04; sel = 4'hF;
    @(posedge clk); #2;
    chk("ack_before_rst", ack, 1);
    #1 rst = 1;
    #1;
    chk("rst_kills_ack", ack, 0);
    chk("rst_kills_dat", dat_o, 0);
    @(negedge clk); cyc = 0; stb = 0;
    idle(2); rst = 0;
    rd(8'h04);

    // randomized traffic
    wr(8'h04, 2); wr(8'h00, 1);
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 11))
        0:       begin o = 8'h00; d = ($urandom_range(0, 7) != 0) ? 32'd1 : 32'd0; end
        1:       begin o = 8'h04; d = $urandom_range(0, 3); end
        2:       begin o = 8'h08; d = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFE : $urandom_range(0, 12); end
        3:       begin o = 8'h0C; d = $urandom; end
        4, 5, 6: begin o = 8'(16 + 8*$urandom_range(0, N-1)); d = $urandom_range(0, 12); end
        7, 8:    begin o = 8'(20 + 8*$urandom_range(0, N-1)); d = $urandom_range(0, 7); end
        9:       begin o = 8'hFC; d = $urandom; end
        default: begin o = 8'h28; d = $urandom; end
      endcase
      s = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
      if ($urandom_range(0, 2) == 0) rd(o);
      else wb(o, 1, d, s, 0);
      idle($urandom_range(0, 3));
    end
    idle(4);
    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
